otter_ir_pipeline: RTL

// - Producer of the per-stage instruction words (DEC/EXE/MEM/WB IR) consumed by the OTTER stage decoders.
// - Shifts IRs down the 5-stage pipe, injects NOP bubbles on load-use/branch hazards and decode-stage CLEAR.
// - Generates EXE-stage operand forwarding selects and a bubble counter.

---
 rtl/otter_pkg.sv | 102 ++++++++++
 rtl/otter_hazard_unit.sv | 45 ++++
 rtl/otter_ir_pipeline.sv | 103 ++++++++++
 3 files changed

// File: rtl/otter_pkg.sv
// Shared OTTER instruction-field helpers: opcodes, register-field extraction and
// operand/destination usage, used by the IR pipeline and the stage decoders.
package otter_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned FWD_W     = 2;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [6:0] {
    OPC_LOAD     = 7'b0000011,
    OPC_MISC_MEM = 7'b0001111,
    OPC_OP_IMM   = 7'b0010011,
    OPC_AUIPC    = 7'b0010111,
    OPC_STORE    = 7'b0100011,
    OPC_OP       = 7'b0110011,
    OPC_LUI      = 7'b0110111,
    OPC_BRANCH   = 7'b1100011,
    OPC_JALR     = 7'b1100111,
    OPC_JAL      = 7'b1101111,
    OPC_SYSTEM   = 7'b1110011
  } opcode_t;

  typedef enum logic [2:0] {
    F3_000   = 3'd0,
    F3_CSRRW = 3'd1,
    F3_010   = 3'd2,
    F3_011   = 3'd3,
    F3_100   = 3'd4,
    F3_101   = 3'd5,
    F3_110   = 3'd6,
    F3_111   = 3'd7
  } func3_t;

  typedef enum logic [FWD_W-1:0] {
    FWD_RF  = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_t;

  function automatic opcode_t get_opcode(input logic [XLEN-1:0] ir);
    return opcode_t'(ir[6:0]);
  endfunction

  function automatic func3_t get_func3(input logic [XLEN-1:0] ir);
    return func3_t'(ir[14:12]);
  endfunction

  function automatic logic [REG_W-1:0] get_rd(input logic [XLEN-1:0] ir);
    return ir[11:7];
  endfunction

  function automatic logic [REG_W-1:0] get_rs1(input logic [XLEN-1:0] ir);
    return ir[19:15];
  endfunction

  function automatic logic [REG_W-1:0] get_rs2(input logic [XLEN-1:0] ir);
    return ir[24:20];
  endfunction

  function automatic logic uses_rs1(input logic [XLEN-1:0] ir);
    case (get_opcode(ir))
      OPC_LUI, OPC_AUIPC, OPC_JAL: return 1'b0;
      default:                     return 1'b1;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [XLEN-1:0] ir);
    case (get_opcode(ir))
      OPC_BRANCH, OPC_STORE, OPC_OP: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

  function automatic logic writes_rd(input logic [XLEN-1:0] ir);
    case (get_opcode(ir))
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
      OPC_OP_IMM, OPC_OP, OPC_LOAD: return 1'b1;
      OPC_SYSTEM:                   return get_func3(ir) == F3_CSRRW;
      default:                      return 1'b0;
    endcase
  endfunction

  function automatic logic is_load(input logic [XLEN-1:0] ir);
    return get_opcode(ir) == OPC_LOAD;
  endfunction

  function automatic logic is_ctrl_dec(input logic [XLEN-1:0] ir);
    return (get_opcode(ir) == OPC_BRANCH) || (get_opcode(ir) == OPC_JALR);
  endfunction

  // Destination register, or x0 when the instruction produces no RF write.
  function automatic logic [REG_W-1:0] dest_reg(input logic [XLEN-1:0] ir);
    return writes_rd(ir) ? get_rd(ir) : '0;
  endfunction

  function automatic logic reads_reg(input logic [XLEN-1:0] ir, input logic [REG_W-1:0] r);
    return (r != '0) &&
           ((uses_rs1(ir) && (get_rs1(ir) == r)) || (uses_rs2(ir) && (get_rs2(ir) == r)));
  endfunction

endpackage

// File: rtl/otter_hazard_unit.sv
// Combinational hazard detection (stall) and EXE-operand forwarding selects
// derived from the registered stage IRs.
module otter_hazard_unit
  import otter_pkg::*;
(
  input  logic [XLEN-1:0]  i_dec_ir,
  input  logic [XLEN-1:0]  i_exe_ir,
  input  logic [XLEN-1:0]  i_mem_ir,
  input  logic [XLEN-1:0]  i_wb_ir,
  output logic             o_stall,
  output logic [FWD_W-1:0] o_fwd_a_sel,
  output logic [FWD_W-1:0] o_fwd_b_sel
);

  logic w_load_use;
  logic w_ctrl_haz;
  logic [REG_W-1:0] w_exe_rs1;
  logic [REG_W-1:0] w_exe_rs2;

  // MEM results win over WB; loads in MEM have no data yet so they never forward.
  function automatic fwd_sel_t fwd_sel(input logic [REG_W-1:0] rs,
                                       input logic [XLEN-1:0]  mem_ir,
                                       input logic [XLEN-1:0]  wb_ir);
    if (rs == '0)                                      return FWD_RF;
    if ((dest_reg(mem_ir) == rs) && !is_load(mem_ir))  return FWD_MEM;
    if (dest_reg(wb_ir) == rs)                         return FWD_WB;
    return FWD_RF;
  endfunction

  always_comb begin
    w_load_use = is_load(i_exe_ir) && reads_reg(i_dec_ir, dest_reg(i_exe_ir));
    w_ctrl_haz = is_ctrl_dec(i_dec_ir) &&
                 (reads_reg(i_dec_ir, dest_reg(i_exe_ir)) ||
                  (is_load(i_mem_ir) && reads_reg(i_dec_ir, dest_reg(i_mem_ir))));
    o_stall    = w_load_use || w_ctrl_haz;
  end

  always_comb begin
    w_exe_rs1   = uses_rs1(i_exe_ir) ? get_rs1(i_exe_ir) : '0;
    w_exe_rs2   = uses_rs2(i_exe_ir) ? get_rs2(i_exe_ir) : '0;
    o_fwd_a_sel = fwd_sel(w_exe_rs1, i_mem_ir, i_wb_ir);
    o_fwd_b_sel = fwd_sel(w_exe_rs2, i_mem_ir, i_wb_ir);
  end

endmodule

// File: rtl/otter_ir_pipeline.sv
// Stage IR registers for the 5-stage OTTER pipe with bubble injection on
// stalls/flushes, a whole-pipe freeze on MEM_BUSY and a saturating bubble counter.
module otter_ir_pipeline
  import otter_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [XLEN-1:0]  FETCH_IR,
  input  logic             FETCH_VALID,
  input  logic             CLEAR,
  input  logic             MEM_BUSY,
  input  logic             CNT_CLR,
  output logic [XLEN-1:0]  DEC_IR,
  output logic [XLEN-1:0]  EXE_IR,
  output logic [XLEN-1:0]  MEM_IR,
  output logic [XLEN-1:0]  WB_IR,
  output logic             PC_WRITE,
  output logic             STALL,
  output logic [FWD_W-1:0] FWD_A_SEL,
  output logic [FWD_W-1:0] FWD_B_SEL,
  output logic [CNT_W-1:0] BUBBLE_CNT
);

  logic [XLEN-1:0]  r_dec_ir, r_exe_ir, r_mem_ir, r_wb_ir;
  logic [XLEN-1:0]  w_dec_nxt, w_exe_nxt, w_mem_nxt, w_wb_nxt;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic             w_stall;
  logic             w_pc_write;
  logic             w_bubble;

  otter_hazard_unit u_hazard (
    .i_dec_ir    (r_dec_ir),
    .i_exe_ir    (r_exe_ir),
    .i_mem_ir    (r_mem_ir),
    .i_wb_ir     (r_wb_ir),
    .o_stall     (w_stall),
    .o_fwd_a_sel (FWD_A_SEL),
    .o_fwd_b_sel (FWD_B_SEL)
  );

  // Priority: MEM_BUSY freeze > hazard stall > decode flush > normal advance.
  always_comb begin
    w_dec_nxt  = r_dec_ir;
    w_exe_nxt  = r_exe_ir;
    w_mem_nxt  = r_mem_ir;
    w_wb_nxt   = r_wb_ir;
    w_pc_write = 1'b0;
    w_bubble   = 1'b0;
    if (!MEM_BUSY) begin
      w_mem_nxt = r_exe_ir;
      w_wb_nxt  = r_mem_ir;
      if (w_stall) begin
        w_exe_nxt = NOP_INSTR;
        w_bubble  = 1'b1;
      end else if (CLEAR) begin
        w_dec_nxt  = NOP_INSTR;
        w_exe_nxt  = r_dec_ir;
        w_pc_write = 1'b1;
        w_bubble   = 1'b1;
      end else begin
        w_dec_nxt  = FETCH_VALID ? FETCH_IR : NOP_INSTR;
        w_exe_nxt  = r_dec_ir;
        w_pc_write = FETCH_VALID;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_dec_ir <= NOP_INSTR;
      r_exe_ir <= NOP_INSTR;
      r_mem_ir <= NOP_INSTR;
      r_wb_ir  <= NOP_INSTR;
    end else begin
      r_dec_ir <= w_dec_nxt;
      r_exe_ir <= w_exe_nxt;
      r_mem_ir <= w_mem_nxt;
      r_wb_ir  <= w_wb_nxt;
    end
  end

  // Saturating bubble counter; a synchronous clear beats a same-cycle increment.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_bubble_cnt <= '0;
    end else if (CNT_CLR) begin
      r_bubble_cnt <= '0;
    end else if (w_bubble && (r_bubble_cnt != '1)) begin
      r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  assign DEC_IR     = r_dec_ir;
  assign EXE_IR     = r_exe_ir;
  assign MEM_IR     = r_mem_ir;
  assign WB_IR      = r_wb_ir;
  assign STALL      = w_stall;
  assign PC_WRITE   = w_pc_write;
  assign BUBBLE_CNT = r_bubble_cnt;

endmodule
